// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, tables and helper functions
package aes_pkg;

   typedef logic [0:15][7:0] state_t;

   typedef enum logic [2:0] {IDLE, LOAD, SUB, MIX, DONE} fsm_t;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Indices past the last AES constant only occur on the unused trailing key step.
   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic int nr(input int key_bits);
      return (key_bits == 256) ? 14 : 10;
   endfunction

   function automatic bit cfg_ok(input int key_bits, input int lanes);
      return ((key_bits == 128) || (key_bits == 256)) && ((lanes == 4) || (lanes == 16));
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - one on-the-fly key schedule step over the key window
module aes_key_step
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 128
) (
   input  logic [KEY_BITS-1:0] win_i,
   input  logic [7:0]          rcon_i,
   input  logic                rot_sel_i,
   output logic [KEY_BITS-1:0] win_o
);

   logic [31:0] sw, temp, n0, n1, n2, n3;

   // SubWord then RotWord equals RotWord then SubWord, so four S-boxes serve both step kinds.
   assign sw   = {sbox(win_i[31:24]), sbox(win_i[23:16]), sbox(win_i[15:8]), sbox(win_i[7:0])};
   assign temp = rot_sel_i ? ({sw[23:0], sw[31:24]} ^ {rcon_i, 24'h0}) : sw;
   assign n0   = win_i[KEY_BITS-1  -: 32] ^ temp;
   assign n1   = win_i[KEY_BITS-33 -: 32] ^ n0;
   assign n2   = win_i[KEY_BITS-65 -: 32] ^ n1;
   assign n3   = win_i[KEY_BITS-97 -: 32] ^ n2;

   if (KEY_BITS == 128) begin : g_k128
      assign win_o = {n0, n1, n2, n3};
   end else begin : g_k256
      assign win_o = {win_i[127:0], n0, n1, n2, n3};
   end

endmodule

// File: rtl/aes_core_iter.sv
// rtl/aes_core_iter.sv - iterative AES-128/256 encryption core with load/done handshake
module aes_core_iter
   import aes_pkg::*;
#(
   parameter int KEY_BITS   = 128,
   parameter int SBOX_LANES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [KEY_BITS-1:0] key,
   input  logic [127:0]        plaintext,
   output logic                done,
   output logic [127:0]        cyphertext
);

   if (!cfg_ok(KEY_BITS, SBOX_LANES)) begin : g_bad_cfg
      $error("aes_core_iter: KEY_BITS must be 128/256 and SBOX_LANES 4/16");
   end

   localparam logic [3:0] NR4   = 4'(nr(KEY_BITS));
   localparam logic [1:0] LLAST = 2'(16 / SBOX_LANES - 1);

   fsm_t                fsm_q, fsm_d;
   state_t              state_q, state_d, sub_state, sr, mc, mix_out;
   logic [KEY_BITS-1:0] key_q, key_d, win_q, win_d, win_src, win_next;
   logic [127:0]        pt_q, pt_d, ct_q, ct_d;
   logic [3:0]          round_q, round_d, rcon_idx_q, rcon_idx_d;
   logic [1:0]          lane_q, lane_d;
   logic                phase_q, phase_d, done_q, done_d, rot_sel;

   // AES-128 rotates on every step; AES-256 alternates Rot and SubWord-only steps.
   assign rot_sel = (KEY_BITS == 128) || !phase_q;
   assign win_src = (fsm_q == LOAD) ? key_q : win_q;

   aes_key_step #(.KEY_BITS(KEY_BITS)) u_key_step (
      .win_i     (win_src),
      .rcon_i    (rcon(rcon_idx_q)),
      .rot_sel_i (rot_sel),
      .win_o     (win_next)
   );

   // SubBytes on the current lane group only.
   always_comb begin
      sub_state = state_q;
      for (int j = 0; j < SBOX_LANES; j++) begin
         sub_state[4'(int'(lane_q) * SBOX_LANES + j)] = sbox(state_q[4'(int'(lane_q) * SBOX_LANES + j)]);
      end
   end

   // ShiftRows, MixColumns (bypassed in the final round) and AddRoundKey.
   always_comb begin
      sr = '0;
      mc = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[4*c+r] = state_q[4*((c+r)%4)+r];
         end
      end
      for (int c = 0; c < 4; c++) begin
         {mc[4*c], mc[4*c+1], mc[4*c+2], mc[4*c+3]} = mix_column({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
      end
      mix_out = ((round_q == NR4) ? sr : mc) ^ win_q[KEY_BITS-1 -: 128];
   end

   // Next-state and datapath control; load always wins and restarts from LOAD.
   always_comb begin
      fsm_d      = fsm_q;
      state_d    = state_q;
      key_d      = key_q;
      pt_d       = pt_q;
      ct_d       = ct_q;
      win_d      = win_q;
      round_d    = round_q;
      lane_d     = lane_q;
      rcon_idx_d = rcon_idx_q;
      phase_d    = phase_q;
      done_d     = done_q;
      if (load) begin
         fsm_d      = LOAD;
         key_d      = key;
         pt_d       = plaintext;
         done_d     = 1'b0;
         round_d    = 4'd0;
         lane_d     = 2'd0;
         rcon_idx_d = 4'd0;
         phase_d    = 1'b0;
      end else begin
         case (fsm_q)
            LOAD: begin
               state_d    = pt_q ^ key_q[KEY_BITS-1 -: 128];
               win_d      = win_next;
               rcon_idx_d = rot_sel ? rcon_idx_q + 4'd1 : rcon_idx_q;
               phase_d    = !phase_q;
               round_d    = 4'd1;
               lane_d     = 2'd0;
               fsm_d      = SUB;
            end
            SUB: begin
               state_d = sub_state;
               if (lane_q == LLAST) begin
                  lane_d = 2'd0;
                  fsm_d  = MIX;
               end else begin
                  lane_d = lane_q + 2'd1;
               end
            end
            MIX: begin
               state_d    = mix_out;
               win_d      = win_next;
               rcon_idx_d = rot_sel ? rcon_idx_q + 4'd1 : rcon_idx_q;
               phase_d    = !phase_q;
               round_d    = round_q + 4'd1;
               if (round_q == NR4) begin
                  ct_d   = mix_out;
                  done_d = 1'b1;
                  fsm_d  = DONE;
               end else begin
                  fsm_d = SUB;
               end
            end
            default: ;
         endcase
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q      <= IDLE;
         state_q    <= '0;
         key_q      <= '0;
         pt_q       <= '0;
         ct_q       <= '0;
         win_q      <= '0;
         round_q    <= '0;
         lane_q     <= '0;
         rcon_idx_q <= '0;
         phase_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         state_q    <= state_d;
         key_q      <= key_d;
         pt_q       <= pt_d;
         ct_q       <= ct_d;
         win_q      <= win_d;
         round_q    <= round_d;
         lane_q     <= lane_d;
         rcon_idx_q <= rcon_idx_d;
         phase_q    <= phase_d;
         done_q     <= done_d;
      end
   end

   assign done       = done_q;
   assign cyphertext = ct_q;

endmodule

// File: tb/tb_aes_core_iter.sv
// tb/tb_aes_core_iter.sv - directed FIPS-197 vector bench for aes_core_iter
module tb_aes_core_iter;

   localparam logic [255:0] KEY_B  = 256'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [255:0] KEY_C  = 256'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [255:0] KEY_D  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT_D   = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic         clk = 1'b0;
   logic         reset;
   logic         load_v [4];
   logic [255:0] key_v  [4];
   logic [127:0] pt_v   [4];
   logic         done_v [4];
   logic [127:0] ct_v   [4];
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   aes_core_iter #(.KEY_BITS(128), .SBOX_LANES(16)) dut_128_16 (
      .clk(clk), .reset(reset), .load(load_v[0]), .key(key_v[0][127:0]),
      .plaintext(pt_v[0]), .done(done_v[0]), .cyphertext(ct_v[0]));
   aes_core_iter #(.KEY_BITS(128), .SBOX_LANES(4)) dut_128_4 (
      .clk(clk), .reset(reset), .load(load_v[1]), .key(key_v[1][127:0]),
      .plaintext(pt_v[1]), .done(done_v[1]), .cyphertext(ct_v[1]));
   aes_core_iter #(.KEY_BITS(256), .SBOX_LANES(16)) dut_256_16 (
      .clk(clk), .reset(reset), .load(load_v[2]), .key(key_v[2]),
      .plaintext(pt_v[2]), .done(done_v[2]), .cyphertext(ct_v[2]));
   aes_core_iter #(.KEY_BITS(256), .SBOX_LANES(4)) dut_256_4 (
      .clk(clk), .reset(reset), .load(load_v[3]), .key(key_v[3]),
      .plaintext(pt_v[3]), .done(done_v[3]), .cyphertext(ct_v[3]));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic run_vec(input int d, input string tag, input logic [255:0] k,
                          input logic [127:0] p, input logic [127:0] exp,
                          input logic [127:0] old_ct, input int lat);
      int   cnt;
      logic held;
      @(negedge clk);
      load_v[d] = 1'b1;
      key_v[d]  = k;
      pt_v[d]   = p;
      @(negedge clk);
      check({tag, "_drop"}, 128'(done_v[d]), 128'd0);
      @(negedge clk);
      load_v[d] = 1'b0;
      cnt  = 0;
      held = 1'b1;
      while (!done_v[d] && cnt < 200) begin
         if (ct_v[d] !== old_ct) held = 1'b0;
         @(negedge clk);
         cnt++;
      end
      check({tag, "_latency"}, 128'(cnt), 128'(lat));
      check({tag, "_ct"}, ct_v[d], exp);
      check({tag, "_held"}, 128'(held), 128'd1);
   endtask

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         load_v[i] = 1'b0;
         key_v[i]  = '0;
         pt_v[i]   = '0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rst_done%0d", i), 128'(done_v[i]), 128'd0);
         check($sformatf("rst_ct%0d", i), ct_v[i], 128'd0);
      end
      reset = 1'b0;

      run_vec(0, "b_128_16", KEY_B, PT_B, CT_B, 128'd0, 21);
      run_vec(1, "c_128_4",  KEY_C, PT_C, CT_C, 128'd0, 51);
      run_vec(2, "d_256_16", KEY_D, PT_C, CT_D, 128'd0, 29);
      run_vec(3, "d_256_4",  KEY_D, PT_C, CT_D, 128'd0, 71);

      run_vec(0, "b2b", KEY_C, PT_C, CT_C, CT_B, 21);

      @(negedge clk);
      load_v[0] = 1'b1;
      key_v[0]  = KEY_C;
      pt_v[0]   = PT_C;
      @(negedge clk);
      load_v[0] = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_nodone", 128'(done_v[0]), 128'd0);
      run_vec(0, "abort_b", KEY_B, PT_B, CT_B, CT_C, 21);

      @(negedge clk);
      load_v[0] = 1'b1;
      key_v[0]  = KEY_C;
      pt_v[0]   = PT_C;
      @(negedge clk);
      load_v[0] = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_done", 128'(done_v[0]), 128'd0);
      check("arst_ct", ct_v[0], 128'd0);
      @(negedge clk);
      reset = 1'b0;
      run_vec(0, "post_rst", KEY_B, PT_B, CT_B, 128'd0, 21);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
